// File: rtl/eth_rx_filter_pkg.sv
// eth_rx_filter_pkg: shared constants and FSM state encoding for the Ethernet RX filter
package eth_rx_filter_pkg;
  localparam int          ETH_HDR_LEN    = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;
  typedef enum logic [2:0] {IDLE, HDR, FWD_HDR, FWD_BODY, DROP} state_t;
endpackage

// File: rtl/eth_rx_filter.sv
// eth_rx_filter: buffers the Ethernet header, forwards frames addressed to us (or broadcast) carrying IPv4/ARP, drops the rest
// Ports: rx_clk / reset (async, active-low); our_mac_address (station MAC, byte 0 in [47:40]);
//        mac_rx_* AXI-Stream byte input; ip_rx_* AXI-Stream byte output; pass_count / drop_count frame counters.
module eth_rx_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int HDR_LEN = ETH_HDR_LEN
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [47:0] our_mac_address,
  input  logic [7:0]  mac_rx_tdata,
  input  logic        mac_rx_tvalid,
  output logic        mac_rx_tready,
  input  logic        mac_rx_tlast,
  output logic [7:0]  ip_rx_tdata,
  output logic        ip_rx_tvalid,
  input  logic        ip_rx_tready,
  output logic        ip_rx_tlast,
  output logic [7:0]  pass_count,
  output logic [7:0]  drop_count
);
  localparam logic [3:0] LAST = 4'(HDR_LEN - 1);
  state_t      r_state;
  logic [3:0]  r_hdr_cnt;
  logic [7:0]  r_buf [HDR_LEN];
  logic        r_hdr_last;
  logic        r_run;
  logic        w_acc;
  logic        w_pass;
  logic [47:0] w_dst;
  logic [15:0] w_type;
  // r_run keeps mac_rx_tready low until the first edge after reset release
  assign mac_rx_tready = r_run & (r_state == FWD_HDR ? 1'b0 : r_state == FWD_BODY ? ip_rx_tready : 1'b1);
  assign ip_rx_tvalid  = r_state == FWD_HDR ? 1'b1 : r_state == FWD_BODY ? mac_rx_tvalid : 1'b0;
  assign ip_rx_tdata   = r_state == FWD_HDR ? r_buf[r_hdr_cnt] : r_state == FWD_BODY ? mac_rx_tdata : 8'd0;
  assign ip_rx_tlast   = r_state == FWD_HDR ? (r_hdr_last && r_hdr_cnt == LAST) :
                         r_state == FWD_BODY ? mac_rx_tlast : 1'b0;
  assign w_acc  = mac_rx_tvalid & mac_rx_tready;
  assign w_dst  = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], r_buf[5]};
  // byte 13 is still on the bus when the decision is taken, so it is used directly
  assign w_type = {r_buf[12], mac_rx_tdata};
  assign w_pass = (w_dst == our_mac_address || w_dst == MAC_BROADCAST) &&
                  (w_type == ETHERTYPE_IPV4 || w_type == ETHERTYPE_ARP);
  // r_hdr_cnt is the write index while collecting the header and the read index while replaying it
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hdr_cnt  <= '0;
      r_hdr_last <= 1'b0;
      r_run      <= 1'b0;
      pass_count <= '0;
      drop_count <= '0;
      for (int i = 0; i < HDR_LEN; i++) r_buf[i] <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        IDLE, HDR: if (w_acc) begin
          r_buf[r_hdr_cnt] <= mac_rx_tdata;
          if (r_hdr_cnt == LAST) begin
            r_hdr_cnt  <= '0;
            r_hdr_last <= mac_rx_tlast;
            r_state    <= w_pass ? FWD_HDR : mac_rx_tlast ? IDLE : DROP;
            if (!w_pass) drop_count <= drop_count + 8'd1;
          end else if (mac_rx_tlast) begin
            r_hdr_cnt  <= '0;
            r_state    <= IDLE;
            drop_count <= drop_count + 8'd1;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            r_state   <= HDR;
          end
        end
        FWD_HDR: if (ip_rx_tready) begin
          if (r_hdr_cnt == LAST) begin
            r_hdr_cnt <= '0;
            r_state   <= r_hdr_last ? IDLE : FWD_BODY;
            if (r_hdr_last) pass_count <= pass_count + 8'd1;
          end else r_hdr_cnt <= r_hdr_cnt + 4'd1;
        end
        FWD_BODY: if (w_acc && mac_rx_tlast) begin
          r_state    <= IDLE;
          pass_count <= pass_count + 8'd1;
        end
        DROP: if (w_acc && mac_rx_tlast) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_filter.sv
// tb_eth_rx_filter: directed self-checking bench for eth_rx_filter
module tb_eth_rx_filter;
  logic        rx_clk = 1'b0;
  logic        reset;
  logic [47:0] our_mac_address;
  logic [7:0]  mac_rx_tdata;
  logic        mac_rx_tvalid;
  logic        mac_rx_tready;
  logic        mac_rx_tlast;
  logic [7:0]  ip_rx_tdata;
  logic        ip_rx_tvalid;
  logic        ip_rx_tready;
  logic        ip_rx_tlast;
  logic [7:0]  pass_count;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [8:0] tx_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] out_q[$];
  int out_cyc[$];
  int acc_cyc[$];
  logic [47:0] src_mac = 48'h0011_2233_4455;
  logic [7:0] ip_pl [33] = '{8'h45, 8'h00, 8'h00, 8'h21, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h11,
                             8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h02, 8'hc0, 8'ha8, 8'h01, 8'h01,
                             8'h04, 8'hd2, 8'h04, 8'hd2, 8'h00, 8'h0d, 8'h00, 8'h00,
                             8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};

  eth_rx_filter dut (
    .rx_clk(rx_clk), .reset(reset), .our_mac_address(our_mac_address),
    .mac_rx_tdata(mac_rx_tdata), .mac_rx_tvalid(mac_rx_tvalid), .mac_rx_tready(mac_rx_tready),
    .mac_rx_tlast(mac_rx_tlast), .ip_rx_tdata(ip_rx_tdata), .ip_rx_tvalid(ip_rx_tvalid),
    .ip_rx_tready(ip_rx_tready), .ip_rx_tlast(ip_rx_tlast),
    .pass_count(pass_count), .drop_count(drop_count)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc++;

  always @(negedge rx_clk) begin
    if (reset && ip_rx_tvalid && ip_rx_tready) begin
      out_q.push_back({ip_rx_tlast, ip_rx_tdata});
      out_cyc.push_back(cyc);
    end
    if (reset && mac_rx_tvalid && mac_rx_tready) acc_cyc.push_back(cyc);
  end

  task automatic mk(input logic [47:0] dst, input logic [15:0] et, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i < 6) b = dst[47-8*i -: 8];
      else if (i < 12) b = src_mac[47-8*(i-6) -: 8];
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else if (len == 47 && et == 16'h0800) b = ip_pl[i-14];
      else b = 8'(i * 7 + 3);
      tx_q.push_back({i == len - 1, b});
    end
  endtask

  task automatic clear_logs();
    tx_q.delete(); exp_q.delete(); out_q.delete(); out_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic drive();
    @(posedge rx_clk); #1;
    for (int i = 0; i < tx_q.size(); i++) begin
      int w = 0;
      mac_rx_tdata = tx_q[i][7:0];
      mac_rx_tlast = tx_q[i][8];
      mac_rx_tvalid = 1'b1;
      @(negedge rx_clk);
      while (!mac_rx_tready && w < 200) begin @(negedge rx_clk); w++; end
      if (w >= 200) begin
        errors++; checks++;
        $display("FAIL drive_timeout byte %0d never accepted", i);
        break;
      end
      @(posedge rx_clk); #1;
    end
    mac_rx_tvalid = 1'b0; mac_rx_tlast = 1'b0; mac_rx_tdata = 8'd0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    while (out_q.size() < n && w < 400) begin @(negedge rx_clk); w++; end
    repeat (4) @(negedge rx_clk);
  endtask

  function automatic int first_diff();
    if (out_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge rx_clk);
    checks++; if (mac_rx_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", mac_rx_tready); end
    checks++; if (ip_rx_tvalid !== 1'b0 || ip_rx_tlast !== 1'b0 || ip_rx_tdata !== 8'd0)
      begin errors++; $display("FAIL rst_ip_out got v=%b l=%b d=%h want 0/0/00", ip_rx_tvalid, ip_rx_tlast, ip_rx_tdata); end
    checks++; if (pass_count !== 8'd0 || drop_count !== 8'd0)
      begin errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", pass_count, drop_count); end
    reset = 1'b1;
    #1;
    checks++; if (mac_rx_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early got %b want 0", mac_rx_tready); end
    @(negedge rx_clk);
    checks++; if (mac_rx_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got %b want 1", mac_rx_tready); end
  endtask

  task automatic test_ipv4();
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h0800, 47);
    exp_q = tx_q;
    drive();
    wait_out(47);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL ipv4_data got %0d bytes diff@%0d want 47 identical", out_q.size(), first_diff()); end
    checks++; if (out_q.size() < 47 || out_q[46] !== 9'h16f) begin errors++; $display("FAIL ipv4_last got %h want 16f", out_q.size() ? out_q[out_q.size()-1] : 9'h0); end
    checks++; if (out_cyc.size() < 1 || acc_cyc.size() < 14 || out_cyc[0] - acc_cyc[13] != 1)
      begin errors++; $display("FAIL ipv4_latency got %0d want 1", (out_cyc.size() && acc_cyc.size() > 13) ? out_cyc[0] - acc_cyc[13] : -1); end
    checks++; if (pass_count !== 8'd1) begin errors++; $display("FAIL ipv4_pass got %0d want 1", pass_count); end
  endtask

  task automatic test_arp();
    clear_logs();
    mk(48'hFFFF_FFFF_FFFF, 16'h0806, 42);
    exp_q = tx_q;
    drive();
    wait_out(42);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL arp_data got %0d bytes diff@%0d want 42 identical", out_q.size(), first_diff()); end
    checks++; if (pass_count !== 8'd2) begin errors++; $display("FAIL arp_pass got %0d want 2", pass_count); end
  endtask

  task automatic test_drop();
    clear_logs();
    mk(48'h001f_233d_cd45, 16'h0800, 47);
    drive();
    wait_out(0);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL drop_mac_out got %0d bytes want 0", out_q.size()); end
    checks++; if (acc_cyc.size() != 47) begin errors++; $display("FAIL drop_mac_acc got %0d want 47", acc_cyc.size()); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_mac_cnt got %0d want 1", drop_count); end
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h86dd, 47);
    drive();
    wait_out(0);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL drop_type_out got %0d bytes want 0", out_q.size()); end
    checks++; if (drop_count !== 8'd2 || pass_count !== 8'd2)
      begin errors++; $display("FAIL drop_type_cnt got %0d/%0d want drop 2 pass 2", drop_count, pass_count); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h0800, 10);
    mk(48'h1f2b_1f2b_1f2b, 16'h0800, 47);
    exp_q = tx_q[10:$];
    drive();
    wait_out(47);
    checks++; if (acc_cyc.size() != 57 || acc_cyc[10] - acc_cyc[9] != 1)
      begin errors++; $display("FAIL b2b_gap got %0d accepted want 57 contiguous", acc_cyc.size()); end
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL runt_drop got %0d want 3", drop_count); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL b2b_data got %0d bytes diff@%0d want 47 identical", out_q.size(), first_diff()); end
    checks++; if (pass_count !== 8'd3) begin errors++; $display("FAIL b2b_pass got %0d want 3", pass_count); end
  endtask

  task automatic test_backpressure();
    bit done = 1'b0;
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h0806, 47);
    exp_q = tx_q;
    fork
      begin drive(); wait_out(47); done = 1'b1; end
      while (!done) begin @(posedge rx_clk); #1; ip_rx_tready = ~ip_rx_tready; end
    join
    ip_rx_tready = 1'b1;
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL bp_data got %0d bytes diff@%0d want 47 identical", out_q.size(), first_diff()); end
    checks++; if (acc_cyc.size() < 15 || out_cyc.size() < 15 || acc_cyc[14] <= out_cyc[13] || acc_cyc[14] != out_cyc[14])
      begin errors++; $display("FAIL bp_hdr_stall got acc14=%0d out13=%0d want acc14>out13", acc_cyc.size() > 14 ? acc_cyc[14] : -1, out_cyc.size() > 13 ? out_cyc[13] : -1); end
    checks++; if (pass_count !== 8'd4) begin errors++; $display("FAIL bp_pass got %0d want 4", pass_count); end
  endtask

  task automatic test_mid_reset();
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h0800, 47);
    tx_q = tx_q[0:20];
    drive();
    @(negedge rx_clk);
    reset = 1'b0;
    #1;
    checks++; if (ip_rx_tvalid !== 1'b0 || ip_rx_tlast !== 1'b0 || ip_rx_tdata !== 8'd0 || mac_rx_tready !== 1'b0)
      begin errors++; $display("FAIL mid_rst_out got v=%b l=%b d=%h r=%b want all 0", ip_rx_tvalid, ip_rx_tlast, ip_rx_tdata, mac_rx_tready); end
    checks++; if (pass_count !== 8'd0 || drop_count !== 8'd0)
      begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", pass_count, drop_count); end
    @(negedge rx_clk);
    reset = 1'b1;
    @(negedge rx_clk);
    checks++; if (mac_rx_tready !== 1'b1) begin errors++; $display("FAIL mid_rel_tready got %b want 1", mac_rx_tready); end
    clear_logs();
    mk(48'h1f2b_1f2b_1f2b, 16'h0800, 47);
    exp_q = tx_q;
    drive();
    wait_out(47);
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL mid_next_data got %0d bytes diff@%0d want 47 identical", out_q.size(), first_diff()); end
    checks++; if (pass_count !== 8'd1 || drop_count !== 8'd0)
      begin errors++; $display("FAIL mid_next_cnt got %0d/%0d want 1/0", pass_count, drop_count); end
  endtask

  initial begin
    reset = 1'b0;
    our_mac_address = 48'h1f2b_1f2b_1f2b;
    mac_rx_tdata = 8'd0; mac_rx_tvalid = 1'b0; mac_rx_tlast = 1'b0;
    ip_rx_tready = 1'b1;
    test_reset();
    test_ipv4();
    test_arp();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
